ingress_request_scheduler: RTL and testbench

- Shares the single master transactor read path of a layer-engine tile between C_NUM_REQ ingress requesters (command decoders, cache refill, weight fetch).
- Accepts 128-bit fetch commands, arbitrates round-robin and issues one read at a time with provided parameters.
- Tracks completion or timeout and returns a per-requester done or error pulse.
- Sits between the ingress command sources and master_transactor.

---
 rtl/ingress_request_scheduler.sv | 145 ++++++++++++++
 tb/tb_ingress_request_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ingress_request_scheduler.sv
// Round-robin scheduler that shares one master_transactor read path between
// C_NUM_REQ requesters, with per-owner done/error pulses and a wait timeout.
module ingress_request_scheduler #(
  parameter int         C_NUM_REQ        = 4,
  parameter int         C_REQ_ID_WIDTH   = 2,
  parameter logic [3:0] C_REQUEST_TYPE   = 4'h1,
  parameter int         C_TIMEOUT_CYCLES = 65535
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [C_NUM_REQ-1:0]       req_valid,
  output logic [C_NUM_REQ-1:0]       req_accept,
  input  logic [C_NUM_REQ*128-1:0]   req_command,
  output logic [C_NUM_REQ-1:0]       req_done,
  output logic [C_NUM_REQ-1:0]       req_error,
  output logic                       xact_request,
  output logic                       xact_use_provided_param,
  output logic [35:0]                xact_length,
  output logic [3:0]                 xact_type,
  output logic [63:0]                xact_address,
  input  logic                       xact_busy,
  input  logic                       xact_complete,
  output logic [C_REQ_ID_WIDTH-1:0]  grant_id,
  output logic                       active
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'b001,
    ST_ISSUE     = 3'b010,
    ST_WAIT_DONE = 3'b100
  } state_t;

  state_t                      r_state, w_next;
  logic [C_REQ_ID_WIDTH-1:0]   r_rr_ptr, r_grant_id, w_winner;
  logic                        w_found;
  logic [63:0]                 r_addr;
  logic [35:0]                 r_len;
  logic [15:0]                 r_timer;
  logic [C_NUM_REQ-1:0]        r_done, r_error;
  logic [127:0]                w_cmd;
  logic                        w_issue, w_finish_ok, w_finish_err, w_drive;
  logic                        w_unused_cmd_bits;

  function automatic logic [C_REQ_ID_WIDTH-1:0] wrap_idx(input int v);
    return C_REQ_ID_WIDTH'(v % C_NUM_REQ);
  endfunction

  function automatic logic [C_NUM_REQ-1:0] onehot(input logic [C_REQ_ID_WIDTH-1:0] idx);
    logic [C_NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < C_NUM_REQ; k++) begin
      if (!w_found && req_valid[wrap_idx(int'(r_rr_ptr) + k)]) begin
        w_found  = 1'b1;
        w_winner = wrap_idx(int'(r_rr_ptr) + k);
      end
    end
  end

  assign w_cmd             = req_command[int'(w_winner)*128 +: 128];
  assign w_unused_cmd_bits = ^w_cmd[27:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_issue      = 1'b0;
    w_finish_ok  = 1'b0;
    w_finish_err = 1'b0;
    req_accept   = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_found && rst) begin
          req_accept = onehot(w_winner);
          w_next     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (r_len == 36'd0) begin
          w_finish_err = 1'b1;
          w_next       = ST_IDLE;
        end else if (!xact_busy) begin
          w_issue = 1'b1;
          w_next  = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        // Completion takes priority over a timeout landing in the same cycle.
        if (xact_complete) begin
          w_finish_ok = 1'b1;
          w_next      = ST_IDLE;
        end else if (r_timer == 16'(C_TIMEOUT_CYCLES - 1)) begin
          w_finish_err = 1'b1;
          w_next       = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr     <= '0;
      r_len      <= '0;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
      r_timer    <= '0;
      r_done     <= '0;
      r_error    <= '0;
    end else begin
      if (r_state == ST_IDLE && w_found) begin
        r_addr     <= w_cmd[127:64];
        r_len      <= w_cmd[63:28];
        r_grant_id <= w_winner;
      end
      if (w_issue)                    r_timer <= '0;
      else if (r_state == ST_WAIT_DONE) r_timer <= r_timer + 16'd1;
      r_done  <= w_finish_ok  ? onehot(r_grant_id) : '0;
      r_error <= w_finish_err ? onehot(r_grant_id) : '0;
      if (w_finish_ok || w_finish_err) r_rr_ptr <= wrap_idx(int'(r_grant_id) + 1);
    end
  end

  assign w_drive                 = w_issue || (r_state == ST_WAIT_DONE);
  assign xact_request            = w_issue;
  assign xact_use_provided_param = w_issue;
  assign xact_address            = w_drive ? r_addr : 64'd0;
  assign xact_length             = w_drive ? r_len : 36'd0;
  assign xact_type               = w_drive ? C_REQUEST_TYPE : 4'd0;
  assign req_done                = r_done;
  assign req_error               = r_error;
  assign grant_id                = r_grant_id;
  assign active                  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_ingress_request_scheduler.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against a transaction-level model.
module tb_ingress_request_scheduler;
  localparam int         N     = 4;
  localparam int         TO    = 16;
  localparam logic [3:0] RTYPE = 4'h1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_accept, req_done, req_error;
  logic [N*128-1:0] req_command = '0;
  logic             xact_busy = 1'b0, xact_complete = 1'b0;
  logic             xact_request, xact_use_provided_param;
  logic [35:0]      xact_length;
  logic [3:0]       xact_type;
  logic [63:0]      xact_address;
  logic [1:0]       grant_id;
  logic             active;

  int total = 0;
  int bad   = 0;

  ingress_request_scheduler #(
    .C_NUM_REQ(N), .C_REQ_ID_WIDTH(2), .C_REQUEST_TYPE(RTYPE), .C_TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_accept(req_accept),
    .req_command(req_command), .req_done(req_done), .req_error(req_error),
    .xact_request(xact_request), .xact_use_provided_param(xact_use_provided_param),
    .xact_length(xact_length), .xact_type(xact_type), .xact_address(xact_address),
    .xact_busy(xact_busy), .xact_complete(xact_complete), .grant_id(grant_id),
    .active(active)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: who owns the path, whether its read went out,
  // how long it has waited, and which pulses are due this cycle.
  typedef struct {
    int          owner;
    int          last;
    int          ptr;
    int          waited;
    int          done_to;
    int          err_to;
    bit          sent;
    logic [63:0] addr;
    logic [35:0] len;
  } mstate_t;

  function automatic mstate_t reset_state();
    mstate_t s;
    s.owner = -1; s.last = 0; s.ptr = 0; s.waited = 0;
    s.done_to = -1; s.err_to = -1; s.sent = 1'b0;
    s.addr = '0; s.len = '0;
    return s;
  endfunction

  mstate_t m, n;
  initial m = reset_state();

  always @(posedge clk) m = rst ? n : reset_state();

  always @(negedge clk) begin
    logic [N-1:0] e_acc, e_done, e_err;
    logic         e_req, e_drive;
    int           w;
    n = m;
    n.done_to = -1;
    n.err_to  = -1;
    e_acc = '0;
    e_req = 1'b0;
    w     = -1;
    if (!rst) begin
      n = reset_state();
    end else if (m.owner < 0) begin
      for (int k = 0; k < N; k++)
        if (w < 0 && req_valid[(m.ptr + k) % N]) w = (m.ptr + k) % N;
      if (w >= 0) begin
        e_acc[w] = 1'b1;
        n.owner  = w;
        n.last   = w;
        n.sent   = 1'b0;
        n.addr   = req_command[128*w + 64 +: 64];
        n.len    = req_command[128*w + 28 +: 36];
      end
    end else if (!m.sent) begin
      if (m.len == 0) begin
        n.err_to = m.owner; n.ptr = (m.owner + 1) % N; n.owner = -1;
      end else if (!xact_busy) begin
        e_req = 1'b1; n.sent = 1'b1; n.waited = 0;
      end
    end else begin
      if (xact_complete) begin
        n.done_to = m.owner; n.ptr = (m.owner + 1) % N; n.owner = -1;
      end else if (m.waited == TO - 1) begin
        n.err_to = m.owner; n.ptr = (m.owner + 1) % N; n.owner = -1;
      end else begin
        n.waited = m.waited + 1;
      end
    end
    e_done  = '0;
    e_err   = '0;
    if (rst && m.done_to >= 0) e_done[m.done_to] = 1'b1;
    if (rst && m.err_to >= 0)  e_err[m.err_to]   = 1'b1;
    e_drive = rst && (e_req || (m.owner >= 0 && m.sent));
    check("m_accept", req_accept, e_acc);
    check("m_request", xact_request, e_req);
    check("m_use_param", xact_use_provided_param, e_req);
    check("m_address", xact_address, e_drive ? m.addr : 64'd0);
    check("m_length", xact_length, e_drive ? m.len : 36'd0);
    check("m_type", xact_type, e_drive ? RTYPE : 4'd0);
    check("m_done", req_done, e_done);
    check("m_error", req_error, e_err);
    check("m_grant_id", grant_id, rst ? 2'(m.last) : 2'd0);
    check("m_active", active, rst && m.owner >= 0);
    check("m_pulse_onehot", $countones(req_done | req_error) <= 1, 1'b1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input int i, input logic [63:0] a, input logic [35:0] l);
    req_command[128*i +: 128] = {a, l, 28'($urandom)};
  endtask

  task automatic do_reset();
    rst = 1'b0; req_valid = '0; xact_busy = 1'b0; xact_complete = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  int          order [5] = '{0, 1, 2, 3, 0};
  logic [3:0]  one = 4'b0001;

  initial begin
    // Single request from requester 1.
    do_reset();
    set_cmd(1, 64'h1000, 36'h40);
    req_valid = 4'b0010;
    #1 check("s1_accept", req_accept, 4'b0010);
    tick(); req_valid = '0;
    #1 check("s1_request", xact_request, 1'b1);
    check("s1_address", xact_address, 64'h1000);
    check("s1_length", xact_length, 36'h40);
    check("s1_type", xact_type, RTYPE);
    check("s1_grant", grant_id, 2'd1);
    repeat (10) tick();
    xact_complete = 1'b1;
    tick(); xact_complete = 1'b0;
    #1 check("s1_done", req_done, 4'b0010);
    check("s1_idle", active, 1'b0);

    // Round robin with all requesters valid.
    do_reset();
    for (int i = 0; i < N; i++) set_cmd(i, 64'h10000 * (i + 1), 36'h100);
    req_valid = 4'hF;
    for (int g = 0; g < 5; g++) begin
      int k;
      k = 0;
      #1;
      while (req_accept == '0 && k < 20) begin tick(); #1; k++; end
      check("s2_grant", req_accept, one << order[g]);
      tick();
      #1 check("s2_issue", xact_request, 1'b1);
      check("s2_addr", xact_address, 64'h10000 * (order[g] + 1));
      repeat (3) tick();
      xact_complete = 1'b1;
      tick(); xact_complete = 1'b0;
    end
    req_valid = '0;

    // Zero-length command from requester 2, requester 3 waiting.
    do_reset();
    set_cmd(2, 64'h3000, 36'h0);
    set_cmd(3, 64'h4000, 36'h20);
    req_valid = 4'b1100;
    #1 check("s3_accept", req_accept, 4'b0100);
    tick();
    #1 check("s3_no_request", xact_request, 1'b0);
    tick();
    #1 check("s3_error", req_error, 4'b0100);
    check("s3_next_grant", req_accept, 4'b1000);
    tick(); req_valid = '0;
    #1 check("s3_req3", xact_request, 1'b1);
    check("s3_addr3", xact_address, 64'h4000);
    tick(); xact_complete = 1'b1;
    tick(); xact_complete = 1'b0;
    #1 check("s3_done3", req_done, 4'b1000);

    // Busy stall followed by timeout, then completion exactly at the limit.
    do_reset();
    set_cmd(0, 64'h2000, 36'h10);
    xact_busy = 1'b1;
    req_valid = 4'b0001;
    #1 check("s4_accept", req_accept, 4'b0001);
    tick(); req_valid = '0;
    for (int i = 0; i < 20; i++) begin
      #1 check("s4_stall_req", xact_request, 1'b0);
      check("s4_stall_err", req_error, 4'b0000);
      tick();
    end
    xact_busy = 1'b0;
    #1 check("s4_issue", xact_request, 1'b1);
    for (int i = 0; i < TO; i++) begin
      tick();
      #1 check("s4_wait_err", req_error, 4'b0000);
    end
    tick();
    #1 check("s4_timeout", req_error, 4'b0001);
    check("s4_timeout_nodone", req_done, 4'b0000);
    set_cmd(0, 64'h2100, 36'h18);
    req_valid = 4'b0001;
    #1 check("s4b_accept", req_accept, 4'b0001);
    tick(); req_valid = '0;
    #1 check("s4b_issue", xact_request, 1'b1);
    repeat (TO) tick();
    xact_complete = 1'b1;
    tick(); xact_complete = 1'b0;
    #1 check("s4b_done", req_done, 4'b0001);
    check("s4b_noerr", req_error, 4'b0000);

    // Reset while waiting for completion.
    set_cmd(2, 64'h5000, 36'h30);
    req_valid = 4'b0100;
    tick(); req_valid = '0;
    tick(); tick(); tick();
    rst = 1'b0;
    req_valid = 4'b1000;
    set_cmd(3, 64'h6000, 36'h44);
    #1 check("s5_active", active, 1'b0);
    check("s5_addr", xact_address, 64'd0);
    check("s5_len", xact_length, 36'd0);
    check("s5_grant", grant_id, 2'd0);
    check("s5_accept_rst", req_accept, 4'b0000);
    tick(); tick();
    rst = 1'b1;
    #1 check("s5_accept", req_accept, 4'b1000);
    tick(); req_valid = '0;
    #1 check("s5_nodone", req_done, 4'b0000);
    check("s5_issue", xact_request, 1'b1);
    check("s5_grant3", grant_id, 2'd3);
    tick(); xact_complete = 1'b1;
    tick(); xact_complete = 1'b0;
    #1 check("s5_done", req_done, 4'b1000);

    // Randomized traffic checked by the model every cycle.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 3) == 0)
          set_cmd(i, {$urandom, $urandom},
                  ($urandom_range(0, 7) == 0) ? 36'd0 : 36'($urandom));
      xact_busy     = ($urandom_range(0, 2) == 0);
      xact_complete = ($urandom_range(0, 11) == 0);
      tick();
    end
    req_valid = '0; xact_busy = 1'b0; xact_complete = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
